// File: rtl/fetch_stage_if.sv
// Bundle of loader, control, redirect, interrupt and issue signals for fetch_stage.
// Names carry the stage's view: i_* flow into the stage, o_* flow out of it.
interface fetch_stage_if #(
  parameter int unsigned IW = 16,
  parameter int unsigned AW = 10
) ();
  logic          i_load_en;
  logic [AW-1:0] i_load_addr;
  logic [IW-1:0] i_load_data;
  logic          i_stall_in;
  logic          i_branch_taken;
  logic [AW-1:0] i_branch_target;
  logic          i_jump_valid;
  logic [AW-1:0] i_jump_target;
  logic          i_irq;
  logic [IW-1:0] o_instr;
  logic [AW-1:0] o_instr_pc;
  logic          o_instr_valid;
  logic [1:0]    o_int_tag_d;
  logic [AW-1:0] o_ret_pc_d;

  // Driver side (loader, control logic, testbench)
  modport master (
    output i_load_en, i_load_addr, i_load_data, i_stall_in,
    output i_branch_taken, i_branch_target, i_jump_valid, i_jump_target, i_irq,
    input  o_instr, o_instr_pc, o_instr_valid, o_int_tag_d, o_ret_pc_d
  );

  // Fetch stage side
  modport slave (
    input  i_load_en, i_load_addr, i_load_data, i_stall_in,
    input  i_branch_taken, i_branch_target, i_jump_valid, i_jump_target, i_irq,
    output o_instr, o_instr_pc, o_instr_valid, o_int_tag_d, o_ret_pc_d
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: local instruction memory with loader port, branch/jump
// redirect, load-use bubbling and a two-cycle interrupt entry (INT_OP, then a
// push-return-PC bubble). The interrupt tag and return PC travel down a delay
// line so they line up with the memory stage.
module fetch_stage #(
  parameter int unsigned IW         = 16,
  parameter int unsigned AW         = 10,
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned INT_VECTOR = 32,
  parameter int unsigned INT_OP     = 8,
  parameter int unsigned LDD_OP     = 10,
  parameter int unsigned POP_OP     = 9,
  parameter int unsigned TAG_DELAY  = 3
) (
  input logic          clk,
  input logic          rst,
  fetch_stage_if.slave bus
);

  localparam int unsigned Depth = 2 ** AW;
  localparam logic [4:0]  IntOp = 5'(INT_OP);
  localparam logic [4:0]  LddOp = 5'(LDD_OP);
  localparam logic [4:0]  PopOp = 5'(POP_OP);
  localparam logic [1:0]  TagNone = 2'd0;
  localparam logic [1:0]  TagInt  = 2'd1;
  localparam logic [1:0]  TagPush = 2'd2;

  typedef enum logic [0:0] {StRun, StIntPush} state_e;

  logic [IW-1:0] r_mem [Depth];

  state_e        r_state;
  logic [AW-1:0] r_fetch_pc;
  logic [AW-1:0] r_saved_pc;
  logic          r_irq_pending;
  logic          r_irq_q;
  logic [IW-1:0] r_instr;
  logic [AW-1:0] r_instr_pc;
  logic          r_instr_valid;
  // Stage 0 is aligned with instr; the last stage is TAG_DELAY cycles later.
  logic [1:0]    r_tag_dl [TAG_DELAY+1];
  logic [AW-1:0] r_ret_dl [TAG_DELAY+1];

  logic [IW-1:0] w_cand;
  logic [4:0]    w_last_op;
  logic [2:0]    w_last_src;
  logic [2:0]    w_last_dst;
  logic [2:0]    w_cand_src;
  logic [2:0]    w_cand_dst;
  logic          w_hazard;
  logic          w_redirect;
  logic [AW-1:0] w_target;
  logic          w_irq_edge;
  logic          w_active;

  state_e        w_state_d;
  logic [AW-1:0] w_fetch_pc_d;
  logic [AW-1:0] w_saved_pc_d;
  logic [IW-1:0] w_instr_d;
  logic [AW-1:0] w_instr_pc_d;
  logic          w_instr_valid_d;
  logic          w_take_irq;
  logic [1:0]    w_tag_new;
  logic [AW-1:0] w_ret_new;

  assign w_cand     = r_mem[r_fetch_pc];
  assign w_last_op  = r_instr[IW-1 -: 5];
  assign w_last_src = r_instr[IW-6 -: 3];
  assign w_last_dst = r_instr[IW-9 -: 3];
  assign w_cand_src = w_cand[IW-6 -: 3];
  assign w_cand_dst = w_cand[IW-9 -: 3];

  // Load-use check against the last issued word; a bubble (opcode 0) never matches,
  // so the held address reissues on the following cycle.
  assign w_hazard = ((w_last_op == LddOp) &&
                     ((w_last_dst == w_cand_src) || (w_last_dst == w_cand_dst))) ||
                    ((w_last_op == PopOp) &&
                     ((w_last_src == w_cand_src) || (w_last_src == w_cand_dst)));

  assign w_redirect = bus.i_branch_taken | bus.i_jump_valid;
  assign w_target   = bus.i_branch_taken ? bus.i_branch_target : bus.i_jump_target;
  assign w_irq_edge = bus.i_irq & ~r_irq_q;
  assign w_active   = ~bus.i_load_en & ~bus.i_stall_in;

  // Next fetch state and issue slot, in priority order below load/stall.
  always_comb begin
    w_state_d       = r_state;
    w_fetch_pc_d    = r_fetch_pc;
    w_saved_pc_d    = r_saved_pc;
    w_instr_d       = r_instr;
    w_instr_pc_d    = r_instr_pc;
    w_instr_valid_d = r_instr_valid;
    w_take_irq      = 1'b0;
    w_tag_new       = TagNone;
    w_ret_new       = '0;
    if (w_active) begin
      if (r_state == StIntPush) begin
        w_instr_d       = '0;
        w_instr_valid_d = 1'b0;
        w_tag_new       = TagPush;
        w_ret_new       = r_saved_pc;
        w_fetch_pc_d    = AW'(INT_VECTOR);
        w_state_d       = StRun;
      end else if (w_redirect) begin
        w_instr_d       = r_mem[w_target];
        w_instr_pc_d    = w_target;
        w_instr_valid_d = 1'b1;
        w_fetch_pc_d    = w_target + AW'(1);
      end else if (r_irq_pending) begin
        w_instr_d       = {IntOp, {(IW-5){1'b0}}};
        w_instr_pc_d    = r_fetch_pc;
        w_instr_valid_d = 1'b1;
        w_tag_new       = TagInt;
        w_saved_pc_d    = r_fetch_pc;
        w_take_irq      = 1'b1;
        w_state_d       = StIntPush;
      end else if (w_hazard) begin
        w_instr_d       = '0;
        w_instr_valid_d = 1'b0;
      end else begin
        w_instr_d       = w_cand;
        w_instr_pc_d    = r_fetch_pc;
        w_instr_valid_d = 1'b1;
        w_fetch_pc_d    = r_fetch_pc + AW'(1);
      end
    end
  end

  // Loader write port; fetch is frozen while it is active so no read/write collision.
  always_ff @(posedge clk) begin
    if (!rst && bus.i_load_en) begin
      r_mem[bus.i_load_addr] <= bus.i_load_data;
    end
  end

  // Fetch FSM, issue register, interrupt edge capture and tag delay line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StRun;
      r_fetch_pc    <= AW'(RESET_PC);
      r_saved_pc    <= '0;
      r_irq_pending <= 1'b0;
      r_irq_q       <= bus.i_irq;  // a level already high at reset release is not an edge
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      for (int unsigned i = 0; i <= TAG_DELAY; i++) begin
        r_tag_dl[i] <= TagNone;
        r_ret_dl[i] <= '0;
      end
    end else begin
      r_state       <= w_state_d;
      r_fetch_pc    <= w_fetch_pc_d;
      r_saved_pc    <= w_saved_pc_d;
      r_instr       <= w_instr_d;
      r_instr_pc    <= w_instr_pc_d;
      r_instr_valid <= w_instr_valid_d;
      r_irq_q       <= bus.i_irq;
      // A fresh edge in the entry cycle is a new request and stays pending.
      if (w_take_irq) r_irq_pending <= 1'b0;
      if (w_irq_edge) r_irq_pending <= 1'b1;
      if (!bus.i_stall_in) begin
        r_tag_dl[0] <= w_tag_new;
        r_ret_dl[0] <= w_ret_new;
        for (int unsigned i = 1; i <= TAG_DELAY; i++) begin
          r_tag_dl[i] <= r_tag_dl[i-1];
          r_ret_dl[i] <= r_ret_dl[i-1];
        end
      end
    end
  end

  assign bus.o_instr       = r_instr;
  assign bus.o_instr_pc    = r_instr_pc;
  assign bus.o_instr_valid = r_instr_valid;
  assign bus.o_int_tag_d   = r_tag_dl[TAG_DELAY];
  assign bus.o_ret_pc_d    = r_ret_dl[TAG_DELAY];

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Parametrised instruction-fetch stage with a synchronous instruction memory, a loader write port, branch/jump redirect, load-use hazard bubbling and a two-cycle interrupt-entry sequence. It sits at the front of the pipeline. It feeds the decode register and delays the interrupt tag and return PC by TAG_DELAY cycles so they reach the memory stage aligned.

## Interface
- IW, 16: instruction width, ≥16; fields are opcode [IW-1:IW-5], src [IW-6:IW-8], dst [IW-9:IW-11]
- AW, 10: address width; memory depth is 2^AW words
- RESET_PC, 0: first fetch address after reset
- INT_VECTOR, 32: fetch address after interrupt entry
- INT_OP, 8: opcode of the injected interrupt instruction
- LDD_OP, 10: load opcode; its destination is the dst field
- POP_OP, 9: pop opcode; its destination is the src field
- TAG_DELAY, 3: depth of the tag/return-PC delay line, ≥1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- load_en  in  1  loader write strobe; freezes fetch while high
- load_addr  in  AW  loader write address
- load_data  in  IW  loader write data
- stall_in  in  1  downstream stall; holds the stage
- branch_taken  in  1  conditional redirect request
- branch_target  in  AW  conditional redirect address
- jump_valid  in  1  unconditional redirect request
- jump_target  in  AW  unconditional redirect address
- irq  in  1  interrupt request, rising-edge sensitive
- instr  out  IW  issued instruction (0 = NOP)
- instr_pc  out  AW  address of instr
- instr_valid  out  1  instr came from memory or is the INT_OP instruction
- int_tag_d  out  2  delayed tag: 0 none, 1 INT_OP, 2 push-return-PC
- ret_pc_d  out  AW  delayed return PC, meaningful when int_tag_d==2

## Operation
- State: fetch_pc (next address to fetch), FSM {RUN, INT_PUSH}, irq_pending, irq_q (previous irq), delay lines.
- irq_pending is set when irq is high and irq_q is low. It is cleared on interrupt entry.
- Per-cycle priority, highest first: rst > load_en > stall_in > INT_PUSH > redirect > interrupt entry > hazard > sequential.
- rst: fetch_pc=RESET_PC, FSM=RUN, irq_pending=0, instr=0, instr_pc=0, instr_valid=0, all delay stages and outputs 0.
- load_en: mem[load_addr]=load_data. All fetch state and outputs hold. The delay line still shifts.
- stall_in: all fetch state and outputs hold. Redirect inputs are ignored; the requester must hold them. The delay line holds.
- Redirect (RUN): branch_taken wins over jump_valid. target=chosen address; instr=mem[target], instr_pc=target, instr_valid=1, fetch_pc=target+1. Zero bubble.
- Interrupt entry (RUN, irq_pending, no redirect this cycle): instr={INT_OP, zeros}, instr_valid=1, instr_pc=fetch_pc, tag=1, saved_pc=fetch_pc, FSM=INT_PUSH.
- INT_PUSH: instr=0, instr_valid=0, tag=2, return PC=saved_pc, fetch_pc=INT_VECTOR, FSM=RUN.
- Hazard (RUN): cand=mem[fetch_pc]. A hazard exists when the last issued instr is LDD_OP with dst equal to cand src or cand dst, or is POP_OP with src equal to cand src or cand dst.
  - On hazard: instr=0, instr_valid=0, fetch_pc unchanged.
  - The bubble has opcode 0, so the same address issues on the next cycle.
- Sequential: instr=cand, instr_pc=fetch_pc, instr_valid=1, fetch_pc=fetch_pc+1.
- Address arithmetic is mod 2^AW; 2^AW-1 wraps to 0.

## Timing
- Memory read is combinational into the registered instr: the address presented in cycle n appears on instr after edge n.
- Fetch issues one instruction per cycle absent stall, load, hazard or interrupt.
- Tag and return PC enter the delay stage each non-stalled cycle. int_tag_d/ret_pc_d lag by exactly TAG_DELAY cycles.
- Interrupt entry costs 2 issue slots (INT_OP + bubble). The first vector instruction issues on the 3rd cycle.
- irq rising edge during INT_PUSH, stall or load stays pending and is taken at the next eligible cycle.
- A redirect coincident with a pending interrupt is taken first; entry happens the cycle after.
- Write and fetch of the same address in the same cycle cannot occur, because fetch is frozen during load.
- rst mid-sequence returns to RUN and discards any pending interrupt.

## Test plan
- Load mem[0..3]={0x0800,0x0900,0x0A00,0x0B00}, release rst: instr_pc 0,1,2,3 on consecutive cycles; instr_valid=1 each.
- mem[4]=LDD_OP with dst=3, mem[5]=src 3: cycle issuing 5 gives instr=0, instr_valid=0; the next cycle gives instr_pc=5. Repeat with POP_OP src=3: same result.
- branch_taken=1, branch_target=0x40 together with jump_valid=1, jump_target=0x80: instr_pc=0x40, then 0x41.
- irq pulse with fetch_pc=0x10: INT_OP instr, instr_valid=1 (tag 1); next cycle bubble; next cycle instr_pc=INT_VECTOR. Three cycles later int_tag_d goes 1 then 2 with ret_pc_d=0x10.
- irq edge coincident with jump to 0x20: jump instr issues first (instr_pc=0x20), then INT_OP, ret_pc=0x21.
- fetch_pc=2^AW-1: next instr_pc wraps to 0. Asserting stall_in for 3 cycles holds all outputs. Asserting rst during INT_PUSH gives all outputs 0 and no vector fetch.
